// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the execution-pipeline CDB arbiter.
// Provides the ROB index / exception code types, the CDB word struct,
// the execution-unit index map and the output-stage state encoding.
package cdb_arbiter_pkg;

   // Datapath and ROB geometry
   localparam int XLEN            = 64;
   localparam int ROB_IDX_LEN     = 4;
   localparam int EXCEPT_CODE_LEN = 4;

   typedef logic [ROB_IDX_LEN-1:0]     rob_idx_t;
   typedef logic [EXCEPT_CODE_LEN-1:0] except_code_t;

   // One word as broadcast on the common data bus
   typedef struct packed {
      rob_idx_t          rob_idx;
      logic [XLEN-1:0]   res_value;
      logic              except_raised;
      except_code_t      except_code;
   } cdb_t;

   // Upper bound on the number of units that may share the bus
   localparam int EU_N_MAX = 8;

   // Fixed slot assignment of execution units on the arbiter inputs
   localparam int EU_LOAD    = 0;
   localparam int EU_INT_ALU = 1;
   localparam int EU_BRANCH  = 2;
   localparam int EU_FPU     = 3;

   // Output stage occupancy
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: searches req starting at ptr, wrapping
// modulo N, and returns the first requester as one-hot and binary index.
// Purely combinational; the caller owns and updates the pointer.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   // First set request at or after ptr, wrapping past N-1 back to 0
   always_comb begin
      int pos;
      // NOTE: combinational logic uses blocking '=' and assigns every output
      // a default first, so no path leaves a value held (no latch).
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int i = 0; i < N; i++) begin
         pos = int'(ptr) + i;
         if (pos >= N) pos = pos - N;
         if (!any && req[pos]) begin
            any      = 1'b1;
            gnt[pos] = 1'b1;
            idx      = PW'(pos);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: collects results offered by the execution
// units, grants one per cycle round-robin and registers the winner into
// a single-entry output stage that drives the CDB towards the ROB.
// Optional build macro CDB_ARB_EU0_PRIO_EN: the load unit (EU 0) gets
// absolute priority and the remaining units rotate among themselves.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int N_EU = 4,
   localparam int PW   = $clog2(N_EU)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic [N_EU-1:0]                eu_valid_i,
   output logic [N_EU-1:0]                eu_ready_o,
   input  rob_idx_t     [N_EU-1:0]        eu_idx_i,
   input  logic         [N_EU-1:0][XLEN-1:0] eu_data_i,
   input  logic [N_EU-1:0]                eu_except_raised_i,
   input  except_code_t [N_EU-1:0]        eu_except_code_i,
   input  logic                           rob_ready_i,
   output logic                           cdb_valid_o,
   output rob_idx_t                       cdb_idx_o,
   output logic [XLEN-1:0]                cdb_data_o,
   output logic                           cdb_except_raised_o,
   output except_code_t                   cdb_except_o
);

   localparam logic [PW-1:0] LAST_EU = PW'(N_EU - 1);

   out_state_e      state_q, state_d;
   cdb_t            cdb_q;
   cdb_t            win_word;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   ptr_next;
   logic [N_EU-1:0] win_gnt;
   logic [PW-1:0]   win_idx;
   logic            any_req;
   logic            can_load;
   logic            grant;

`ifdef CDB_ARB_EU0_PRIO_EN
   // Units 1..N_EU-1 rotate among themselves; pointer lives in 1..N_EU-1
   localparam int            NS      = N_EU - 1;
   localparam int            SPW     = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [PW-1:0] PTR_RST = PW'(1);

   logic [SPW-1:0] sub_ptr;
   logic [SPW-1:0] sub_idx;
   logic [NS-1:0]  sub_gnt;
   logic           sub_any;

   assign sub_ptr = SPW'(rr_ptr - PW'(1));

   rr_arbiter #(.N(NS)) u_rr (
      .req (eu_valid_i[N_EU-1:1]),
      .ptr (sub_ptr),
      .gnt (sub_gnt),
      .idx (sub_idx),
      .any (sub_any)
   );

   // Load unit wins outright; otherwise take the rotating sub-arbiter result
   always_comb begin
      win_gnt = '0;
      win_idx = '0;
      any_req = 1'b0;
      if (eu_valid_i[EU_LOAD]) begin
         win_gnt[EU_LOAD] = 1'b1;
         win_idx          = PW'(EU_LOAD);
         any_req          = 1'b1;
      end else begin
         win_gnt = {sub_gnt, 1'b0};
         win_idx = PW'(sub_idx) + PW'(1);
         any_req = sub_any;
      end
   end

   // Pointer advance: untouched by a load-unit grant, wraps back to 1
   always_comb begin
      ptr_next = rr_ptr;
      if (win_idx == PW'(EU_LOAD)) ptr_next = rr_ptr;
      else if (win_idx == LAST_EU) ptr_next = PTR_RST;
      else                         ptr_next = win_idx + PW'(1);
   end
`else
   localparam logic [PW-1:0] PTR_RST = '0;

   rr_arbiter #(.N(N_EU)) u_rr (
      .req (eu_valid_i),
      .ptr (rr_ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (any_req)
   );

   // Pointer advance: one past the winner, wrapping to 0 after the last unit
   always_comb begin
      ptr_next = (win_idx == LAST_EU) ? PTR_RST : win_idx + PW'(1);
   end
`endif

   // Winner's fields, selected for loading into the output stage
   always_comb begin
      win_word.rob_idx       = eu_idx_i[win_idx];
      win_word.res_value     = eu_data_i[win_idx];
      win_word.except_raised = eu_except_raised_i[win_idx];
      win_word.except_code   = eu_except_code_i[win_idx];
   end

   // The stage can take a new word when empty or when the ROB drains it now
   assign can_load = !flush_i && ((state_q == OUT_EMPTY) || rob_ready_i);
   assign grant    = |eu_ready_o;

   // Output stage state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state is updated with non-blocking '<=' so every
      // register samples the pre-edge values of the others.
      if (rst_i) state_q <= OUT_EMPTY;
      else       state_q <= state_d;
   end

   // Output stage next state: flush empties, grant fills, drain empties
   always_comb begin
      state_d = state_q;
      if (flush_i)                                    state_d = OUT_EMPTY;
      else if (grant)                                 state_d = OUT_FULL;
      else if (state_q == OUT_FULL && rob_ready_i)    state_d = OUT_EMPTY;
   end

   // Grant outputs: one-hot winner only when the stage can accept it
   always_comb begin
      eu_ready_o = '0;
      if (!rst_i && can_load && any_req) eu_ready_o = win_gnt;
   end

   // Round-robin pointer: restarts on flush, advances on every grant
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        rr_ptr <= PTR_RST;
      else if (flush_i) rr_ptr <= PTR_RST;
      else if (grant)   rr_ptr <= ptr_next;
   end

   // CDB word register: loads the granted result, otherwise holds
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: the payload is reset as well so the bus reads all-zero after
      // reset instead of exposing stale or X data to snooping stations.
      if (rst_i)      cdb_q <= '0;
      else if (grant) cdb_q <= win_word;
   end

   assign cdb_valid_o         = (state_q == OUT_FULL);
   assign cdb_idx_o           = cdb_q.rob_idx;
   assign cdb_data_o          = cdb_q.res_value;
   assign cdb_except_raised_o = cdb_q.except_raised;
   assign cdb_except_o        = cdb_q.except_code;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (N_EU=4). Stimulus pushes the
// hand-expected CDB word for each expected grant; a negedge monitor pops
// and compares every word the ROB accepts.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic                      clk;
   logic                      rst_i;
   logic                      flush_i;
   logic [3:0]                eu_valid;
   logic [3:0]                eu_ready_o;
   rob_idx_t     [3:0]        eu_idx;
   logic         [3:0][XLEN-1:0] eu_data;
   logic [3:0]                eu_exc;
   except_code_t [3:0]        eu_code;
   logic                      rob_ready;
   logic                      cdb_valid_o;
   rob_idx_t                  cdb_idx_o;
   logic [XLEN-1:0]           cdb_data_o;
   logic                      cdb_except_raised_o;
   except_code_t              cdb_except_o;

   cdb_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [3:0] all_exp  [5];
   logic [3:0] alt_exp  [3];

   cdb_arbiter #(.N_EU(4)) dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .flush_i             (flush_i),
      .eu_valid_i          (eu_valid),
      .eu_ready_o          (eu_ready_o),
      .eu_idx_i            (eu_idx),
      .eu_data_i           (eu_data),
      .eu_except_raised_i  (eu_exc),
      .eu_except_code_i    (eu_code),
      .rob_ready_i         (rob_ready),
      .cdb_valid_o         (cdb_valid_o),
      .cdb_idx_o           (cdb_idx_o),
      .cdb_data_o          (cdb_data_o),
      .cdb_except_raised_o (cdb_except_raised_o),
      .cdb_except_o        (cdb_except_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Check grant vector and queue the expected word for the granted unit
   task automatic expect_gnt(input logic [3:0] exp, input string nm);
      cdb_t w;
      check(nm, 64'(eu_ready_o), 64'(exp));
      for (int k = 0; k < 4; k++) begin
         if (exp[k]) begin
            w.rob_idx       = eu_idx[k];
            w.res_value     = eu_data[k];
            w.except_raised = eu_exc[k];
            w.except_code   = eu_code[k];
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic drop_word(input string nm);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s: expected queue empty, nothing to discard", nm);
      else begin
         void'(exp_q.pop_front());
         n_pass++;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic [3:0] exp, input string nm);
      @(negedge clk);
      expect_gnt(exp, nm);
      adv();
   endtask

   // Monitor: every word the ROB accepts must match the queue head
   always @(negedge clk) begin
      if (!rst_i && cdb_valid_o && rob_ready && !flush_i) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL cdb_unexpected: got idx %0h data %0h with nothing expected", cdb_idx_o, cdb_data_o);
         end else begin
            cdb_t e;
            e = exp_q.pop_front();
            check("cdb_idx",  64'(cdb_idx_o),           64'(e.rob_idx));
            check("cdb_data", cdb_data_o,               e.res_value);
            check("cdb_exc",  64'(cdb_except_raised_o), 64'(e.except_raised));
            check("cdb_code", 64'(cdb_except_o),        64'(e.except_code));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef CDB_ARB_EU0_PRIO_EN
      all_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      alt_exp = '{4'b0001, 4'b0001, 4'b0001};
`else
      all_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      alt_exp = '{4'b0001, 4'b0010, 4'b0001};
`endif
      rst_i     = 1'b1;
      flush_i   = 1'b0;
      rob_ready = 1'b1;
      eu_valid  = 4'hF;
      for (int k = 0; k < 4; k++) begin
         eu_idx[k]  = rob_idx_t'(k + 1);
         eu_data[k] = 64'h1000 + 64'(k);
         eu_exc[k]  = 1'b0;
         eu_code[k] = '0;
      end

      // Reset state
      #3;
      check("rst_ready",     64'(eu_ready_o),          64'h0);
      check("rst_valid",     64'(cdb_valid_o),         64'h0);
      check("rst_idx",       64'(cdb_idx_o),           64'h0);
      check("rst_data",      cdb_data_o,               64'h0);
      check("rst_exc",       64'(cdb_except_raised_o), 64'h0);
      check("rst_code",      64'(cdb_except_o),        64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_i    = 1'b0;
      eu_valid = 4'b0000;

      // Single request from EU2
      eu_idx[2]  = rob_idx_t'(5);
      eu_data[2] = 64'hDEAD;
      eu_valid   = 4'b0100;
      cyc(4'b0100, "single_gnt");
      eu_valid = 4'b0000;
      @(negedge clk);
      expect_gnt(4'b0000, "single_idle");
      check("single_valid", 64'(cdb_valid_o), 64'h1);
      adv();

      // Pointer now 3: EU3 beats EU1
      eu_valid = 4'b1010;
      cyc(4'b1000, "ptr_after_eu2");
      eu_valid = 4'b0000;
      cyc(4'b0000, "idle_drain");
      @(negedge clk);
      check("empty_after_drain", 64'(cdb_valid_o), 64'h0);
      adv();

      // All four continuously valid, back-to-back
      for (int k = 0; k < 4; k++) eu_data[k] = 64'hA000 + 64'(k);
      eu_valid = 4'hF;
      for (int i = 0; i < 5; i++) cyc(all_exp[i], $sformatf("all_gnt%0d", i));

      // Flush with a full stage, ROB ready and EU0 valid
      flush_i  = 1'b1;
      eu_valid = 4'b0001;
      @(negedge clk);
      expect_gnt(4'b0000, "flush_nogrant");
      drop_word("flush_drop");
      adv();
      flush_i  = 1'b0;
      eu_valid = 4'b0000;
      @(negedge clk);
      check("flush_empty", 64'(cdb_valid_o), 64'h0);
      expect_gnt(4'b0000, "flush_idle");
      adv();

      // Pointer back at 0 after flush; EU0 word with idx 7 fills the stage
      eu_idx[0] = rob_idx_t'(7);
      eu_valid  = 4'hF;
      cyc(4'b0001, "ptr_after_flush");

      // Back-pressure: word held, no grant while ROB stalls
      rob_ready = 1'b0;
      eu_valid  = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_gnt(4'b0000, "bp_nogrant");
         check("bp_valid", 64'(cdb_valid_o), 64'h1);
         check("bp_idx",   64'(cdb_idx_o),   64'h7);
         adv();
      end
      rob_ready = 1'b1;
      cyc(4'b0010, "bp_release");

      // Exception propagation from EU3
      eu_exc[3]  = 1'b1;
      eu_code[3] = except_code_t'(2);
      eu_valid   = 4'b1000;
      cyc(4'b1000, "exc_gnt");
      eu_valid = 4'b0000;
      @(negedge clk);
      expect_gnt(4'b0000, "exc_idle");
      check("exc_flag", 64'(cdb_except_raised_o), 64'h1);
      check("exc_code", 64'(cdb_except_o),        64'h2);
      adv();
      eu_exc[3]  = 1'b0;
      eu_code[3] = '0;

      // EU0 and EU1 both valid for three cycles
      eu_valid = 4'b0011;
      for (int i = 0; i < 3; i++) cyc(alt_exp[i], $sformatf("alt_gnt%0d", i));

      // Reset in the middle of a held transfer discards the word
      eu_valid = 4'b0010;
      cyc(4'b0010, "pre_reset_gnt");
      rob_ready = 1'b0;
      eu_valid  = 4'hF;
      @(negedge clk);
      expect_gnt(4'b0000, "pre_reset_hold");
      check("pre_reset_valid", 64'(cdb_valid_o), 64'h1);
      #1;
      rst_i = 1'b1;
      #1;
      check("midrst_valid", 64'(cdb_valid_o), 64'h0);
      check("midrst_data",  cdb_data_o,       64'h0);
      check("midrst_ready", 64'(eu_ready_o),  64'h0);
      drop_word("midrst_drop");
      adv();
      rst_i     = 1'b0;
      eu_valid  = 4'b0000;
      rob_ready = 1'b1;
      repeat (3) adv();
      check("final_valid", 64'(cdb_valid_o),  64'h0);
      check("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
